// File: rtl/mem_pkg.sv
// Shared definitions for the wait-state memory responder: op3 codes, FSM states
// and access-size decode.
package mem_pkg;

    localparam logic [5:0] OP_LD    = 6'b000000;
    localparam logic [5:0] OP_FETCH = 6'b001000;
    localparam logic [5:0] OP_LDUB  = 6'b000001;
    localparam logic [5:0] OP_LDSB  = 6'b001001;
    localparam logic [5:0] OP_LDUH  = 6'b000010;
    localparam logic [5:0] OP_LDSH  = 6'b001010;
    localparam logic [5:0] OP_ST    = 6'b000100;
    localparam logic [5:0] OP_STB   = 6'b000101;
    localparam logic [5:0] OP_STH   = 6'b000110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    typedef struct packed {
        logic  valid;
        logic  is_store;
        logic  sign_ext;
        size_t size;
    } op_info_t;

    function automatic op_info_t decode_op(input logic [5:0] op);
        op_info_t info;
        info.valid    = 1'b1;
        info.is_store = 1'b0;
        info.sign_ext = 1'b0;
        info.size     = SZ_WORD;
        case (op)
            OP_LD, OP_FETCH: info.size = SZ_WORD;
            OP_LDUB: info.size = SZ_BYTE;
            OP_LDSB: begin
                info.size     = SZ_BYTE;
                info.sign_ext = 1'b1;
            end
            OP_LDUH: info.size = SZ_HALF;
            OP_LDSH: begin
                info.size     = SZ_HALF;
                info.sign_ext = 1'b1;
            end
            OP_ST: info.is_store = 1'b1;
            OP_STB: begin
                info.is_store = 1'b1;
                info.size     = SZ_BYTE;
            end
            OP_STH: begin
                info.is_store = 1'b1;
                info.size     = SZ_HALF;
            end
            default: info.valid = 1'b0;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/mem_lane_ext.sv
// Combinational lane logic: alignment check, big-endian lane select with
// sign/zero extension for loads, and byte-enable/replicated data for stores.
module mem_lane_ext
    import mem_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rd_word,
    input  logic [31:0] wr_data,
    output logic [31:0] load_data,
    output logic [31:0] wr_word,
    output logic [3:0]  byte_en,
    output logic        is_load,
    output logic        misalign,
    output logic        bad_op
);

    op_info_t   info;
    logic [7:0] offset_byte [4];
    logic [7:0] sel_byte;
    logic [15:0] sel_half;

    assign info = decode_op(opcode);

    // offset_byte[o] is the byte at address offset o (offset 0 is the MSB lane)
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign offset_byte[gi] = rd_word[31-8*gi -: 8];
        end
    endgenerate

    assign sel_byte = offset_byte[addr_lo];
    assign sel_half = addr_lo[1] ? rd_word[15:0] : rd_word[31:16];

    always_comb begin
        load_data = rd_word;
        wr_word   = wr_data;
        byte_en   = 4'b1111;
        misalign  = 1'b0;
        case (info.size)
            SZ_BYTE: begin
                load_data = {{24{info.sign_ext & sel_byte[7]}}, sel_byte};
                wr_word   = {4{wr_data[7:0]}};
                byte_en   = 4'b1000 >> addr_lo;
            end
            SZ_HALF: begin
                load_data = {{16{info.sign_ext & sel_half[15]}}, sel_half};
                wr_word   = {2{wr_data[15:0]}};
                byte_en   = addr_lo[1] ? 4'b0011 : 4'b1100;
                misalign  = addr_lo[0];
            end
            default: misalign = |addr_lo;
        endcase
        if (!info.valid) begin
            misalign = 1'b0;
        end
        if (!info.valid || !info.is_store || misalign) begin
            byte_en = 4'b0000;
        end
    end

    assign is_load = info.valid & ~info.is_store;
    assign bad_op  = ~info.valid;

endmodule

// File: rtl/mem_responder_ws.sv
// Memory responder with programmable wait states: accepts an MFA request,
// counts down WAIT_STATES, performs a big-endian access, then holds MFC until MFA drops.
module mem_responder_ws
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 9,
    parameter int WAIT_STATES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              MFA,
    input  logic [5:0]        Opcode,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       DataIn,
    output logic [31:0]       DataOut,
    output logic              MFC,
    output logic              MisAlign,
    output logic              BadOp
);

    localparam int         WORDS     = 2 ** (ADDR_W - 2);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    state_t              state_reg, state_next;
    logic [3:0]          cnt_reg, cnt_next;
    logic [5:0]          op_reg, op_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [31:0]         wdata_reg, wdata_next;
    logic [31:0]         data_out_reg, data_out_next;
    logic                mfc_reg, mfc_next;
    logic                misalign_reg, misalign_next;
    logic                bad_op_reg, bad_op_next;
    logic [31:0]         rd_word_reg;

    logic [31:0] mem [WORDS];

    logic        access;
    logic        rd_en;
    logic        mem_we;
    logic [31:0] load_data;
    logic [31:0] wr_word;
    logic [3:0]  byte_en;
    logic        is_load;
    logic        misalign;
    logic        bad_op;

    mem_lane_ext u_lane_ext (
        .opcode    (op_reg),
        .addr_lo   (addr_reg[1:0]),
        .rd_word   (rd_word_reg),
        .wr_data   (wdata_reg),
        .load_data (load_data),
        .wr_word   (wr_word),
        .byte_en   (byte_en),
        .is_load   (is_load),
        .misalign  (misalign),
        .bad_op    (bad_op)
    );

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        op_next       = op_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        data_out_next = data_out_reg;
        mfc_next      = mfc_reg;
        misalign_next = misalign_reg;
        bad_op_next   = bad_op_reg;
        access        = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (MFA) begin
                    op_next    = Opcode;
                    addr_next  = Address;
                    wdata_next = DataIn;
                    cnt_next   = WAIT_LOAD;
                    state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_reg == 4'd0) begin
                    access        = 1'b1;
                    mfc_next      = 1'b1;
                    misalign_next = misalign;
                    bad_op_next   = bad_op;
                    if (is_load && !misalign) begin
                        data_out_next = load_data;
                    end
                    state_next = S_DONE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            S_DONE: begin
                if (!MFA) begin
                    mfc_next      = 1'b0;
                    misalign_next = 1'b0;
                    bad_op_next   = 1'b0;
                    state_next    = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= 4'd0;
            op_reg       <= 6'd0;
            addr_reg     <= '0;
            wdata_reg    <= 32'd0;
            data_out_reg <= 32'd0;
            mfc_reg      <= 1'b0;
            misalign_reg <= 1'b0;
            bad_op_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            op_reg       <= op_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            data_out_reg <= data_out_next;
            mfc_reg      <= mfc_next;
            misalign_reg <= misalign_next;
            bad_op_reg   <= bad_op_next;
        end
    end

    // The word is fetched on the acceptance edge so it is ready even with zero wait states
    assign rd_en  = (state_reg == S_IDLE) && MFA;
    assign mem_we = access && !Reset;

    always_ff @(posedge Clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[addr_reg[ADDR_W-1:2]][i*8 +: 8] <= wr_word[i*8 +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_word_reg <= mem[Address[ADDR_W-1:2]];
        end
    end

    assign DataOut  = data_out_reg;
    assign MFC      = mfc_reg;
    assign MisAlign = misalign_reg;
    assign BadOp    = bad_op_reg;

endmodule

// File: tb/tb_mem_responder_ws.sv
// Self-checking bench for mem_responder_ws: directed table, handshake corner
// sequences and randomized requests checked against a byte-array memory model.
module tb_mem_responder_ws;

    localparam int ADDR_W = 9;
    localparam int WS     = 2;
    localparam int DEPTH  = 2 ** ADDR_W;

    localparam logic [5:0] M_LD    = 6'b000000;
    localparam logic [5:0] M_FETCH = 6'b001000;
    localparam logic [5:0] M_LDUB  = 6'b000001;
    localparam logic [5:0] M_LDSB  = 6'b001001;
    localparam logic [5:0] M_LDUH  = 6'b000010;
    localparam logic [5:0] M_LDSH  = 6'b001010;
    localparam logic [5:0] M_ST    = 6'b000100;
    localparam logic [5:0] M_STB   = 6'b000101;
    localparam logic [5:0] M_STH   = 6'b000110;

    logic              Clk;
    logic              Reset;
    logic              MFA;
    logic [5:0]        Opcode;
    logic [ADDR_W-1:0] Address;
    logic [31:0]       DataIn;
    logic [31:0]       DataOut;
    logic              MFC;
    logic              MisAlign;
    logic              BadOp;

    mem_responder_ws #(.ADDR_W(ADDR_W), .WAIT_STATES(WS)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .MFA      (MFA),
        .Opcode   (Opcode),
        .Address  (Address),
        .DataIn   (DataIn),
        .DataOut  (DataOut),
        .MFC      (MFC),
        .MisAlign (MisAlign),
        .BadOp    (BadOp)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int pass_cnt  = 0;
    int check_cnt = 0;

    logic [7:0]  model_mem [DEPTH];
    logic [31:0] model_dout;

    typedef struct {
        logic [5:0]  op;
        logic [8:0]  addr;
        logic [31:0] din;
        logic [31:0] dout;
        logic        mis;
        logic        bad;
    } vec_t;

    vec_t tbl [24];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Reference: big-endian byte memory, sizes and alignment from the opcode table
    task automatic model_apply(input logic [5:0] op, input logic [8:0] a, input logic [31:0] d,
                               output logic [31:0] e_dout, output logic e_mis, output logic e_bad);
        int     sz;
        bit     ld;
        bit     sgn;
        longint val;
        sz = 0; ld = 0; sgn = 0;
        e_mis = 1'b0; e_bad = 1'b0;
        case (op)
            M_LD, M_FETCH: begin sz = 4; ld = 1; end
            M_LDUB: begin sz = 1; ld = 1; end
            M_LDSB: begin sz = 1; ld = 1; sgn = 1; end
            M_LDUH: begin sz = 2; ld = 1; end
            M_LDSH: begin sz = 2; ld = 1; sgn = 1; end
            M_ST:   sz = 4;
            M_STB:  sz = 1;
            M_STH:  sz = 2;
            default: sz = 0;
        endcase
        if (sz == 0) begin
            e_bad = 1'b1;
        end else if (int'(a) % sz != 0) begin
            e_mis = 1'b1;
        end else if (ld) begin
            val = 0;
            for (int i = 0; i < sz; i++) val = val * 256 + longint'(model_mem[int'(a) + i]);
            if (sgn && val >= (longint'(1) << (8 * sz - 1))) val = val - (longint'(1) << (8 * sz));
            model_dout = val[31:0];
        end else begin
            for (int i = 0; i < sz; i++) model_mem[int'(a) + i] = 8'(d >> (8 * (sz - 1 - i)));
        end
        e_dout = model_dout;
    endtask

    // One complete handshake; inputs are scrambled after acceptance to prove they were latched
    task automatic run_req(input string name, input logic [5:0] op, input logic [8:0] a,
                           input logic [31:0] d, input logic [31:0] e_dout,
                           input logic e_mis, input logic e_bad);
        int lat;
        @(negedge Clk);
        MFA = 1'b1; Opcode = op; Address = a; DataIn = d;
        lat = 0;
        do begin
            @(negedge Clk);
            lat++;
            if (lat == 1) begin
                Opcode  = 6'($urandom);
                Address = 9'($urandom);
                DataIn  = $urandom;
            end
        end while (!MFC && lat < 40);
        chk({name, " latency"}, 32'(lat), 32'(WS + 2));
        chk({name, " DataOut"}, DataOut, e_dout);
        chk({name, " MisAlign"}, 32'(MisAlign), 32'(e_mis));
        chk({name, " BadOp"}, 32'(BadOp), 32'(e_bad));
        $display("txn %s op=%b addr=%h din=%h dout=%h mis=%b bad=%b lat=%0d",
                 name, op, a, d, DataOut, MisAlign, BadOp, lat);
        MFA = 1'b0;
        @(negedge Clk);
        chk({name, " MFC drop"}, 32'(MFC), 32'd0);
        chk({name, " flags clear"}, {30'd0, MisAlign, BadOp}, 32'd0);
    endtask

    logic [31:0] e_dout;
    logic        e_mis;
    logic        e_bad;
    logic [5:0]  ops [9];

    initial begin
        int lat;
        logic [5:0] rop;
        logic [8:0] raddr;
        logic [31:0] rdat;

        Reset = 1'b1; MFA = 1'b0; Opcode = 6'd0; Address = '0; DataIn = 32'd0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'd0;
        model_dout = 32'd0;
        repeat (3) @(negedge Clk);
        chk("reset MFC", 32'(MFC), 32'd0);
        chk("reset DataOut", DataOut, 32'd0);
        chk("reset MisAlign", 32'(MisAlign), 32'd0);
        chk("reset BadOp", 32'(BadOp), 32'd0);
        Reset = 1'b0;

        // known memory contents for the model
        for (int w = 0; w < DEPTH; w += 4) run_req("fill", M_ST, 9'(w), 32'd0, 32'd0, 1'b0, 1'b0);

        tbl[0]  = '{M_ST,    9'h008, 32'hA2044012, 32'h00000000, 1'b0, 1'b0};
        tbl[1]  = '{M_FETCH, 9'h008, 32'h0,        32'hA2044012, 1'b0, 1'b0};
        tbl[2]  = '{M_STB,   9'h011, 32'h000000FF, 32'hA2044012, 1'b0, 1'b0};
        tbl[3]  = '{M_LDSB,  9'h011, 32'h0,        32'hFFFFFFFF, 1'b0, 1'b0};
        tbl[4]  = '{M_LDUB,  9'h011, 32'h0,        32'h000000FF, 1'b0, 1'b0};
        tbl[5]  = '{M_LD,    9'h010, 32'h0,        32'h00FF0000, 1'b0, 1'b0};
        tbl[6]  = '{M_STH,   9'h020, 32'h00008001, 32'h00FF0000, 1'b0, 1'b0};
        tbl[7]  = '{M_LDSH,  9'h020, 32'h0,        32'hFFFF8001, 1'b0, 1'b0};
        tbl[8]  = '{M_LDUH,  9'h020, 32'h0,        32'h00008001, 1'b0, 1'b0};
        tbl[9]  = '{M_LDSH,  9'h021, 32'h0,        32'h00008001, 1'b1, 1'b0};
        tbl[10] = '{M_LD,    9'h020, 32'h0,        32'h80010000, 1'b0, 1'b0};
        tbl[11] = '{6'b111111, 9'h000, 32'h0,      32'h80010000, 1'b0, 1'b1};
        tbl[12] = '{M_ST,    9'h1FC, 32'h12345678, 32'h80010000, 1'b0, 1'b0};
        tbl[13] = '{M_LD,    9'h1FC, 32'h0,        32'h12345678, 1'b0, 1'b0};
        tbl[14] = '{M_ST,    9'h042, 32'hFFFFFFFF, 32'h12345678, 1'b1, 1'b0};
        tbl[15] = '{M_ST,    9'h040, 32'h11223344, 32'h12345678, 1'b0, 1'b0};
        tbl[16] = '{M_LD,    9'h040, 32'h0,        32'h11223344, 1'b0, 1'b0};
        tbl[17] = '{M_LDUB,  9'h1FF, 32'h0,        32'h00000078, 1'b0, 1'b0};
        tbl[18] = '{M_LDSH,  9'h1FE, 32'h0,        32'h00005678, 1'b0, 1'b0};
        tbl[19] = '{M_STH,   9'h026, 32'h1234ABCD, 32'h00005678, 1'b0, 1'b0};
        tbl[20] = '{M_LD,    9'h024, 32'h0,        32'h0000ABCD, 1'b0, 1'b0};
        tbl[21] = '{M_LDUH,  9'h013, 32'h0,        32'h0000ABCD, 1'b1, 1'b0};
        tbl[22] = '{6'b000011, 9'h000, 32'h0,      32'h0000ABCD, 1'b0, 1'b1};
        tbl[23] = '{M_LDSB,  9'h010, 32'h0,        32'h00000000, 1'b0, 1'b0};

        for (int i = 0; i < 24; i++) begin
            model_apply(tbl[i].op, tbl[i].addr, tbl[i].din, e_dout, e_mis, e_bad);
            run_req($sformatf("tbl%0d", i), tbl[i].op, tbl[i].addr, tbl[i].din,
                    tbl[i].dout, tbl[i].mis, tbl[i].bad);
        end

        // MFA held after MFC, then reasserted the cycle MFC falls
        model_apply(M_LD, 9'h010, 32'h0, e_dout, e_mis, e_bad);
        @(negedge Clk);
        MFA = 1'b1; Opcode = M_LD; Address = 9'h010; DataIn = 32'h0;
        lat = 0;
        do begin @(negedge Clk); lat++; end while (!MFC && lat < 40);
        chk("hold latency", 32'(lat), 32'(WS + 2));
        chk("hold DataOut", DataOut, e_dout);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            chk($sformatf("hold MFC %0d", i), 32'(MFC), 32'd1);
        end
        $display("txn hold LD addr=010 dout=%h", DataOut);
        MFA = 1'b0;
        @(negedge Clk);
        chk("hold MFC drop", 32'(MFC), 32'd0);
        model_apply(M_LDUB, 9'h011, 32'h0, e_dout, e_mis, e_bad);
        MFA = 1'b1; Opcode = M_LDUB; Address = 9'h011;
        lat = 0;
        do begin @(negedge Clk); lat++; end while (!MFC && lat < 40);
        chk("reassert latency", 32'(lat), 32'(WS + 2));
        chk("reassert DataOut", DataOut, e_dout);
        $display("txn reassert LDUB addr=011 dout=%h lat=%0d", DataOut, lat);
        MFA = 1'b0;
        @(negedge Clk);
        chk("reassert MFC drop", 32'(MFC), 32'd0);

        // MFA dropped during BUSY: access still completes, MFC pulses for one cycle
        model_apply(M_LDSB, 9'h011, 32'h0, e_dout, e_mis, e_bad);
        @(negedge Clk);
        MFA = 1'b1; Opcode = M_LDSB; Address = 9'h011;
        @(negedge Clk);
        MFA = 1'b0;
        lat = 1;
        do begin @(negedge Clk); lat++; end while (!MFC && lat < 40);
        chk("early drop latency", 32'(lat), 32'(WS + 2));
        chk("early drop DataOut", DataOut, e_dout);
        $display("txn early-drop LDSB addr=011 dout=%h lat=%0d", DataOut, lat);
        @(negedge Clk);
        chk("early drop MFC fall", 32'(MFC), 32'd0);

        // Reset in the middle of a store aborts it
        @(negedge Clk);
        MFA = 1'b1; Opcode = M_ST; Address = 9'h040; DataIn = 32'hDEADBEEF;
        @(negedge Clk);
        Reset = 1'b1; MFA = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        chk("abort MFC", 32'(MFC), 32'd0);
        chk("abort DataOut", DataOut, 32'd0);
        chk("abort MisAlign", 32'(MisAlign), 32'd0);
        chk("abort BadOp", 32'(BadOp), 32'd0);
        $display("txn reset-abort ST addr=040 din=deadbeef");
        model_dout = 32'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            chk($sformatf("abort quiet %0d", i), 32'(MFC), 32'd0);
        end
        model_apply(M_LD, 9'h040, 32'h0, e_dout, e_mis, e_bad);
        run_req("after abort", M_LD, 9'h040, 32'h0, e_dout, e_mis, e_bad);

        // Randomized requests vs model
        ops = '{M_LD, M_FETCH, M_LDUB, M_LDSB, M_LDUH, M_LDSH, M_ST, M_STB, M_STH};
        for (int n = 0; n < 150; n++) begin
            rop   = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 8)];
            raddr = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(0, 31));
            rdat  = $urandom;
            model_apply(rop, raddr, rdat, e_dout, e_mis, e_bad);
            run_req("rnd", rop, raddr, rdat, e_dout, e_mis, e_bad);
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/mem_responder_ws.md
Name: mem_responder_ws

Overview:
- Responder end of the datapath memory handshake. The control unit or bench drives MFA, opcode, address and write data; this block answers with MFC and read data after a programmable number of wait states.
- Replaces the combinational RAM model when cycle-accurate memory latency is required for control-unit bring-up.
- Byte-addressed, big-endian storage. Supports SPARC load/store op3 sizes plus the team's instruction-fetch opcode.

Parameters:
- ADDR_W, 9, byte-address width; memory depth is 2^ADDR_W bytes.
- WAIT_STATES, 2, cycles inserted between request acceptance and MFC assertion; legal range 0..15.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- MFA  in  1  memory function activate; level request held by the initiator until MFC is seen.
- Opcode  in  6  access type; op3 encoding, see Behaviour.
- Address  in  ADDR_W  byte address.
- DataIn  in  32  store data; the right-justified lane is used for byte and halfword stores.
- DataOut  out  32  load result; held until the next completed load.
- MFC  out  1  memory function complete.
- MisAlign  out  1  the completed request was misaligned.
- BadOp  out  1  the completed request carried an unsupported opcode.

Behaviour:
- Reset (synchronous, Reset=1 at a rising edge):
  - MFC=0, DataOut=0, MisAlign=0, BadOp=0, wait counter=0, state IDLE.
  - Memory contents are not cleared.
  - Reset during BUSY aborts the access; no write occurs.
- States: IDLE, BUSY, DONE.
- IDLE:
  - On an edge with MFA=1: latch Opcode, Address and DataIn; load counter with WAIT_STATES; go to BUSY.
  - MFC stays 0.
- BUSY:
  - Counter decrements each edge.
  - On the edge where the counter equals 0: perform the access, set MFC=1 and the error flags, go to DONE.
  - MFA dropping during BUSY is ignored; the access completes.
- Latency: MFA sampled high at edge t gives MFC=1 after edge t+WAIT_STATES+1. With WAIT_STATES=0, MFC rises on the edge after acceptance.
- DONE:
  - MFC held at 1 while MFA=1.
  - On the first edge with MFA=0: MFC=0 and go to IDLE.
  - A new request needs MFA low for at least one edge (no back-to-back without the drop).
- Opcodes:
  - 000000 LD word
  - 001000 FETCH word (same as LD)
  - 000001 LDUB, zero-extended
  - 001001 LDSB, sign-extended
  - 000010 LDUH, zero-extended
  - 001010 LDSH, sign-extended
  - 000100 ST word
  - 000101 STB, DataIn[7:0]
  - 000110 STH, DataIn[15:0]
- Byte order: big-endian. A word at A is mem[A] in bits [31:24] through mem[A+3] in bits [7:0].
- Alignment: word accesses need Address[1:0]=00; halfword accesses need Address[0]=0.
- Misaligned request: MFC asserted normally, MisAlign=1, no write, DataOut unchanged.
- Unlisted opcode: MFC asserted, BadOp=1, no write, DataOut unchanged.
- Error flags: valid only while MFC=1; cleared on return to IDLE.
- Stores: DataOut unchanged.
- Address wrap: the last word (2^ADDR_W−4) is legal; no out-of-range is possible because the address width matches the depth.

Decomposition:
- Shared package mem_pkg: op3 constants (OP_LD, OP_FETCH, OP_LDUB, OP_LDSB, OP_LDUH, OP_LDSH, OP_ST, OP_STB, OP_STH), the IDLE/BUSY/DONE state encoding, and the access-size enum.
- One sub-module, mem_lane_ext: combinational alignment check, lane select and sign/zero extension for loads, plus byte-enable generation for stores.
- Storage array, FSM and counter stay in mem_responder_ws.

Test Plan:
- Reset, then FETCH at Address 0x008 with WAIT_STATES=2 and preloaded word 0xA2044012 -> MFC rises 3 edges after acceptance; DataOut=0xA2044012; MisAlign=0; BadOp=0.
- STB 0x000000FF at 0x011, then LDSB at 0x011 -> DataOut=0xFFFFFFFF. LDUB at 0x011 -> 0x000000FF. LD at 0x010 -> bits [23:16]=0xFF, other bytes unchanged.
- STH 0x00008001 at 0x020, LDSH -> DataOut=0xFFFF8001; LDUH -> 0x00008001. LDSH at 0x021 -> MisAlign=1, DataOut unchanged, memory unchanged.
- Hold MFA high 5 cycles after MFC -> MFC stays 1. Drop MFA -> MFC=0 the next edge. Reassert MFA the same cycle MFC falls -> accepted only from IDLE, with a fresh WAIT_STATES delay.
- ST 0xDEADBEEF at 0x040, assert Reset mid-BUSY -> MFC=0, all outputs zero, and a later LD at 0x040 returns the old contents. Opcode 111111 -> MFC=1, BadOp=1.
